wash_sequencer: RTL

Timed phase sequencer for the washing machine controller. On a start request it steps through FILL, optional WARM, WASH, DRAIN and DRY, holding each phase for a programmable number of prescaled ticks, and drives exactly one actuator output per phase. Door-open and faucet-loss interlocks pause the cycle without losing progress. The block owns the internal prescaler and phase timer and directly drives the actuator enables.

---
 rtl/wash_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - timed wash phase sequencer with door/faucet interlocks
module wash_sequencer #(
  parameter int unsigned TW      = 8,
  parameter int unsigned DIV     = 4,
  parameter int unsigned T_FILL  = 2,
  parameter int unsigned T_WARM  = 2,
  parameter int unsigned T_WASH  = 3,
  parameter int unsigned T_DRAIN = 2,
  parameter int unsigned T_DRY   = 2
) (
  input  logic       inp_freq_i,
  input  logic       rst_i,
  input  logic       washing_program_i,
  input  logic       faucet_i,
  input  logic       door_i,
  input  logic       do_i,
  output logic       fill_o,
  output logic       warm_o,
  output logic       wash_o,
  output logic       drain_o,
  output logic       dry_o,
  output logic [2:0] s_o,
  output logic       paused_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WARM  = 3'd2,
    ST_WASH  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DRY   = 3'd5,
    ST_DONE  = 3'd6
  } phase_e;

  localparam logic [TW-1:0] DIV_M1   = TW'(DIV - 1);
  localparam logic [TW-1:0] FILL_M1  = TW'(T_FILL - 1);
  localparam logic [TW-1:0] WARM_M1  = TW'(T_WARM - 1);
  localparam logic [TW-1:0] WASH_M1  = TW'(T_WASH - 1);
  localparam logic [TW-1:0] DRAIN_M1 = TW'(T_DRAIN - 1);
  localparam logic [TW-1:0] DRY_M1   = TW'(T_DRY - 1);

  phase_e        state_q, state_d, next_phase;
  logic [TW-1:0] pre_q, pre_d, tmr_q, tmr_d, len_m1;
  logic          prog_q, prog_d;
  logic          running, pause_cond, tick;
  logic          fill_q, warm_q, wash_q, drain_q, dry_q, paused_q, done_q;

  assign running    = state_q inside {ST_FILL, ST_WARM, ST_WASH, ST_DRAIN, ST_DRY};
  assign pause_cond = running && (door_i || (state_q == ST_FILL && !faucet_i));
  assign tick       = (pre_q == DIV_M1);

  // Last timer value and successor of the current phase; WARM only on the hot program
  always_comb begin
    len_m1     = FILL_M1;
    next_phase = ST_IDLE;
    case (state_q)
      ST_FILL:  begin len_m1 = FILL_M1;  next_phase = prog_q ? ST_WARM : ST_WASH; end
      ST_WARM:  begin len_m1 = WARM_M1;  next_phase = ST_WASH;  end
      ST_WASH:  begin len_m1 = WASH_M1;  next_phase = ST_DRAIN; end
      ST_DRAIN: begin len_m1 = DRAIN_M1; next_phase = ST_DRY;   end
      ST_DRY:   begin len_m1 = DRY_M1;   next_phase = ST_DONE;  end
      default:  ;
    endcase
  end

  // Next phase and counters; a pause condition freezes counting even on a tick edge
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    tmr_d   = tmr_q;
    prog_d  = prog_q;
    case (state_q)
      ST_IDLE: begin
        if (do_i && !door_i && faucet_i) begin
          state_d = ST_FILL;
          prog_d  = washing_program_i;
          pre_d   = '0;
          tmr_d   = '0;
        end
      end
      ST_DONE: begin
        if (!do_i) state_d = ST_IDLE;
      end
      ST_FILL, ST_WARM, ST_WASH, ST_DRAIN, ST_DRY: begin
        if (!pause_cond) begin
          if (!tick) begin
            pre_d = pre_q + 1'b1;
          end else begin
            pre_d = '0;
            if (tmr_q == len_m1) begin
              state_d = next_phase;
              tmr_d   = '0;
            end else begin
              tmr_d = tmr_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs derived from the next state
  always_ff @(posedge inp_freq_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      pre_q    <= '0;
      tmr_q    <= '0;
      prog_q   <= 1'b0;
      fill_q   <= 1'b0;
      warm_q   <= 1'b0;
      wash_q   <= 1'b0;
      drain_q  <= 1'b0;
      dry_q    <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      tmr_q    <= tmr_d;
      prog_q   <= prog_d;
      fill_q   <= (state_d == ST_FILL)  && !pause_cond;
      warm_q   <= (state_d == ST_WARM)  && !pause_cond;
      wash_q   <= (state_d == ST_WASH)  && !pause_cond;
      drain_q  <= (state_d == ST_DRAIN) && !pause_cond;
      dry_q    <= (state_d == ST_DRY)   && !pause_cond;
      paused_q <= pause_cond;
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign s_o      = state_q;
  assign fill_o   = fill_q;
  assign warm_o   = warm_q;
  assign wash_o   = wash_q;
  assign drain_o  = drain_q;
  assign dry_o    = dry_q;
  assign paused_o = paused_q;
  assign done_o   = done_q;

endmodule
